// File: rtl/led_share_arbiter.sv
// Round-robin owner of the shared board LED; renders the owner's 2-bit pattern code on an active-low pin.
// Latency: grant one edge after a request is seen in IDLE; led lags grant/phase by one edge.
// Backpressure: none; requests are level-held and a waiting requester is served once the owner's hold expires.
module led_share_arbiter #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 10,
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int IW  = $clog2(N_REQ);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
  localparam logic [IW-1:0] OWNER_RST  = IW'(N_REQ - 1);
  localparam logic [IW:0]   N_REQ_W    = (IW + 1)'(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     presc;
  logic [3:0]        phase;
  logic [HW-1:0]     hold;
  logic [IW-1:0]     last_owner;

  logic              tick;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [IW:0]       cand;
  logic [N_REQ-1:0]  pick_oh;
  logic              issue;
  logic [N_REQ-1:0]  grant_nxt;
  logic              owner_req;
  logic              others_req;
  logic [1:0]        owner_pat;
  logic              pat_on;
  logic              led_nxt;

  // Terminal count of the prescaler marks one pattern tick.
  assign tick = (presc == PRESC_LAST);

  // While a grant is held, last_owner is the current owner.
  assign owner_req  = req[last_owner];
  assign others_req = |(req & ~grant);
  assign owner_pat  = pattern[{last_owner, 1'b0} +: 2];

  // Round-robin pick: first asserted request searching upward from last_owner+1 with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_owner} + (IW + 1)'(i);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end
      if (!pick_vld && req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
    pick_oh = N_REQ'(1) << pick_idx;
  end

  // Next-state and next-grant: issue from IDLE, release on owner drop or expired hold under contention.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_vld) begin
          state_nxt = GRANT;
          issue     = 1'b1;
          grant_nxt = pick_oh;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if ((hold == HOLD_MAX) && others_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Decode the owner's live pattern code against the current phase.
  always_comb begin
    pat_on = 1'b0;
    case (owner_pat)
      2'b00:   pat_on = 1'b0;
      2'b01:   pat_on = 1'b1;
      2'b10:   pat_on = (phase < 4'd5);
      default: pat_on = ~phase[0];
    endcase
    led_nxt = (|grant) ? ~pat_on : 1'b1;
  end

  // FSM state, grant register and remembered owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      last_owner <= OWNER_RST;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      busy  <= |grant_nxt;
      if (issue) begin
        last_owner <= pick_idx;
      end
    end
  end

  // Prescaler, phase and hold counters; a grant issue overrides a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      phase <= '0;
      hold  <= '0;
    end else if (issue) begin
      presc <= '0;
      phase <= '0;
      hold  <= '0;
    end else if (tick) begin
      presc <= '0;
      phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
      if (hold != HOLD_MAX) begin
        hold <= hold + HW'(1);
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Registered active-low LED output; dark whenever nobody owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b1;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: directed scenarios plus random traffic against a cycle-count reference model.
// The model tracks only owner, last owner and edges elapsed since the grant; counters are derived arithmetically.
// Outputs are sampled 1 time unit after each rising edge; inputs change only at those points.
module tb_led_share_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam int DIV  = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [2*N-1:0] pattern;
  logic [N-1:0] grant;
  logic         busy;
  logic         led;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int   m_owner;
  int   m_last;
  int   m_n;
  logic m_led;

  always #5 clk = ~clk;

  led_share_arbiter #(
    .CLK_HZ(100),
    .TICK_HZ(10),
    .N_REQ(N),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .pattern(pattern),
    .grant(grant),
    .busy(busy),
    .led(led)
  );

  function automatic logic lit(int code, int ph);
    logic r;
    case (code)
      0:       r = 1'b0;
      1:       r = 1'b1;
      2:       r = (ph < 5);
      default: r = ((ph % 2) == 0);
    endcase
    return r;
  endfunction

  function automatic logic req_bit(int idx);
    return ((int'(req) >> idx) & 1) != 0;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int  hold;
    int  code;
    int  c;
    logic found;
    logic others;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_n     = 0;
      m_led   = 1'b1;
    end else begin
      if (m_owner < 0) begin
        m_led = 1'b1;
      end else begin
        code  = (int'(pattern) >> (2 * m_owner)) & 3;
        m_led = ~lit(code, (m_n / DIV) % 10);
      end
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req_bit(c)) begin
            found   = 1'b1;
            m_owner = c;
            m_last  = c;
            m_n     = 0;
          end
        end
      end else begin
        hold   = (m_n / DIV < HOLD) ? m_n / DIV : HOLD;
        others = (int'(req) & ~(1 << m_owner) & ((1 << N) - 1)) != 0;
        if (!req_bit(m_owner) || (hold == HOLD && others)) begin
          m_owner = -1;
        end else begin
          m_n = m_n + 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // One clock: update the model at the edge, then compare all outputs.
  task automatic step();
    logic [N-1:0] eg;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    chk("grant", grant, eg);
    chk("busy", {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, (m_owner >= 0)});
    chk("led", {{(N-1){1'b0}}, led}, {{(N-1){1'b0}}, m_led});
  endtask

  initial begin
    int lows;
    int seq[$];
    logic [N-1:0] prev;
    int zrun;
    int bad_gap;

    m_owner = -1; m_last = N - 1; m_n = 0; m_led = 1'b1;

    // reset with every requester asking
    rst = 1'b1; req = 4'b1111; pattern = 8'hFF;
    repeat (3) step();
    chk("reset_grant", grant, 4'b0000);
    rst = 1'b0;
    step();
    chk("first_arb", grant, 4'b0001);
    req = 4'b0000;
    repeat (2) step();

    // solid on, then release
    req = 4'b0100; pattern = 8'b0001_0000;
    step();
    chk("solid_grant", grant, 4'b0100);
    step();
    chk("solid_led", {3'b000, led}, 4'b0000);
    req = 4'b0000;
    step();
    chk("rel_grant", grant, 4'b0000);
    step();
    chk("rel_led", {3'b000, led}, 4'b0001);

    // slow blink on requester 1
    req = 4'b0010; pattern = 8'b0000_1000;
    lows = 0;
    for (int i = 0; i < 101; i++) begin
      step();
      if (led === 1'b0) lows++;
    end
    chk("slow_lows", N'(lows), N'(50 % 16));
    checks++;
    assert (lows == 50) else begin
      errors++;
      $error("FAIL slow_low_count observed=%0d expected=50", lows);
    end
    req = 4'b0000;
    repeat (2) step();

    // round-robin rotation from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b1111; pattern = 8'b1101_1011;
    prev = '0; zrun = 0; bad_gap = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      if (grant != prev && grant != '0) begin
        seq.push_back(int'(grant));
        if (prev == '0 && seq.size() > 1 && zrun != 1) bad_gap++;
      end
      zrun = (grant == '0) ? zrun + 1 : 0;
      prev = grant;
    end
    checks++;
    assert (seq.size() >= 5 && seq[0] == 1 && seq[1] == 2 && seq[2] == 4 && seq[3] == 8 && seq[4] == 1)
    else begin
      errors++;
      $error("FAIL rotation_seq observed_count=%0d expected=1,2,4,8,1", seq.size());
    end
    checks++;
    assert (bad_gap == 0) else begin
      errors++;
      $error("FAIL rotation_gap observed=%0d expected=0", bad_gap);
    end

    // no preemption before the hold expires
    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0; req = 4'b0001; pattern = 8'b0000_0001;
    step();
    chk("np_grant", grant, 4'b0001);
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) req = 4'b1001;
      step();
    end
    chk("np_hold", grant, 4'b0001);
    step();
    chk("np_gap", grant, 4'b0000);
    req = 4'b1000; pattern = 8'b1100_0001;
    step();
    chk("np_next", grant, 4'b1000);

    // fast blink, then switch to off mid-grant
    repeat (45) step();
    pattern = 8'b0000_0001;
    step();
    chk("sw_led", {3'b000, led}, 4'b0001);
    chk("sw_grant", grant, 4'b1000);
    repeat (3) step();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) req = N'($urandom);
      if ($urandom_range(0, 29) == 0) pattern = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
